lvds_ddr_aligner: RTL and testbench

LVDS_DDR_ALIGNER -- requirements
Module: lvds_ddr_aligner

---
 rtl/lvds_ddr_aligner_if.sv | 11 +
 rtl/lvds_ddr_aligner.sv | 213 +++++++++++++++++++++
 tb/tb_lvds_ddr_aligner.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_ddr_aligner_if.sv
// Aligned frame stream between the DDR aligner (master) and its consumer (slave).
interface lvds_ddr_aligner_if #(
    parameter int FRAME_W = 32
);
    logic [FRAME_W-1:0] frame_data;
    logic               frame_valid;
    logic               frame_ready;

    modport master (output frame_data, output frame_valid, input frame_ready);
    modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/lvds_ddr_aligner.sv
// LVDS DDR deserialiser/aligner: builds beats from rise/fall lane samples,
// assembles RATIO beats into a frame, searches beat offset and DDR phase
// against a training word, then streams locked frames through a 2-entry FIFO.
//
// state  | meaning
// SEARCH | compare each frame to the training word, slip/toggle phase on miss
// VERIFY | count consecutive matches until MATCH_COUNT
// LOCKED | alignment frozen; frames go to the output FIFO while train_en=0
module lvds_ddr_aligner #(
    parameter int                 LANES       = 8,
    parameter int                 RATIO       = 2,
    parameter int                 FRAME_W     = 2*LANES*RATIO,
    parameter logic [FRAME_W-1:0] TRAIN_WORD  = FRAME_W'(32'hA5C3_3C5A),
    parameter int                 MATCH_COUNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES-1:0]   din_rise_i,
    input  logic [LANES-1:0]   din_fall_i,
    input  logic               train_en_i,
    lvds_ddr_aligner_if.master frame_if,
    output logic               locked_o,
    output logic               align_err_o,
    output logic               overflow_o
);

    localparam int         BEAT_W     = 2*LANES;
    localparam logic [3:0] LAST_BEAT  = 4'(RATIO-1);
    localparam logic [3:0] LAST_SLIP  = 4'(RATIO-1);
    localparam logic [4:0] LAST_MISS  = 5'(2*RATIO-1);
    localparam logic [3:0] LAST_MATCH = 4'(MATCH_COUNT-1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t             state_q;
    logic [LANES-1:0]   rise_q;
    logic [BEAT_W-1:0]  beat;
    logic [FRAME_W-1:0] acc_q, acc_d;
    logic [3:0]         beat_cnt_q, beat_cnt_d;
    logic               slip_q, phase_q, train_q;
    logic [3:0]         slip_cnt_q, match_cnt_q;
    logic [4:0]         miss_cnt_q;
    logic               locked_q, align_err_q, overflow_q;
    logic               frame_done, frame_match, push, pop, full, wr_en;
    logic [FRAME_W-1:0] mem_q [2];
    logic               rd_ptr_q, wr_ptr_q;
    logic [1:0]         count_q, count_d;

    // Beat assembly; phase 1 pairs the previous rising sample with the current falling one.
    always_comb begin
        beat = '0;
        for (int i = 0; i < LANES; i++) begin
            if (phase_q) begin
                beat[2*i]   = rise_q[i];
                beat[2*i+1] = din_fall_i[i];
            end else begin
                beat[2*i]   = din_fall_i[i];
                beat[2*i+1] = din_rise_i[i];
            end
        end
    end

    // Frame accumulator with this cycle's beat dropped into its slot; first beat lands in the LSBs.
    always_comb begin
        acc_d = acc_q;
        acc_d[int'(beat_cnt_q)*BEAT_W +: BEAT_W] = beat;
        beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? 4'd0 : beat_cnt_q + 4'd1;
    end

    assign frame_done  = !slip_q && (beat_cnt_q == LAST_BEAT);
    assign frame_match = (acc_d == TRAIN_WORD);
    assign push        = frame_done && (state_q == LOCKED) && !train_en_i;
    assign full        = (count_q == 2'd2);
    assign pop         = frame_if.frame_valid && frame_if.frame_ready;

    // Beat counter and accumulator; a slip cycle discards its beat and holds the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q     <= '0;
            acc_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            rise_q <= din_rise_i;
            if (!slip_q) begin
                acc_q      <= acc_d;
                beat_cnt_q <= beat_cnt_d;
            end
        end
    end

    // Alignment FSM: offset/phase search, match verification and lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            phase_q     <= 1'b0;
            slip_q      <= 1'b0;
            train_q     <= 1'b0;
            slip_cnt_q  <= '0;
            miss_cnt_q  <= '0;
            match_cnt_q <= '0;
            locked_q    <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            train_q <= train_en_i;
            slip_q  <= 1'b0;
            case (state_q)
                SEARCH: begin
                    if (frame_done && train_en_i) begin
                        if (frame_match) begin
                            slip_cnt_q <= '0;
                            miss_cnt_q <= '0;
                            if (MATCH_COUNT == 1) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                state_q     <= VERIFY;
                                match_cnt_q <= 4'd1;
                            end
                        end else begin
                            slip_q <= 1'b1;
                            // every offset in this phase tried: try the other phase
                            if (slip_cnt_q == LAST_SLIP) begin
                                phase_q    <= ~phase_q;
                                slip_cnt_q <= '0;
                            end else begin
                                slip_cnt_q <= slip_cnt_q + 4'd1;
                            end
                            // both phases exhausted: flag and keep sweeping
                            if (miss_cnt_q == LAST_MISS) begin
                                align_err_q <= 1'b1;
                                miss_cnt_q  <= '0;
                            end else begin
                                miss_cnt_q <= miss_cnt_q + 5'd1;
                            end
                        end
                    end
                end
                VERIFY: begin
                    if (frame_done && train_en_i) begin
                        if (frame_match) begin
                            if (match_cnt_q == LAST_MATCH) begin
                                state_q     <= LOCKED;
                                locked_q    <= 1'b1;
                                match_cnt_q <= '0;
                            end else begin
                                match_cnt_q <= match_cnt_q + 4'd1;
                            end
                        end else begin
                            state_q     <= SEARCH;
                            slip_q      <= 1'b1;
                            match_cnt_q <= '0;
                            slip_cnt_q  <= '0;
                            miss_cnt_q  <= '0;
                        end
                    end
                end
                LOCKED: begin
                    // retrain request keeps phase and beat offset as the starting point
                    if (train_en_i && !train_q) begin
                        state_q     <= SEARCH;
                        locked_q    <= 1'b0;
                        match_cnt_q <= '0;
                        slip_cnt_q  <= '0;
                        miss_cnt_q  <= '0;
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    // FIFO occupancy; a push into a full FIFO only lands if a pop frees the head slot.
    always_comb begin
        wr_en   = push && (!full || pop);
        count_d = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!wr_en && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // Two-entry output FIFO with sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= acc_d;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign frame_if.frame_data  = mem_q[rd_ptr_q];
    assign frame_if.frame_valid = (count_q != 2'd0);
    assign locked_o             = locked_q;
    assign align_err_o          = align_err_q;
    assign overflow_o           = overflow_q;

endmodule

// File: tb/tb_lvds_ddr_aligner.sv
// Bench for lvds_ddr_aligner at LANES=2, RATIO=2, TRAIN_WORD=8'hA5, MATCH_COUNT=4.
module tb_lvds_ddr_aligner;
    localparam int FRAME_W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] din_rise = '0;
    logic [1:0] din_fall = '0;
    logic       train_en = 1'b0;
    logic       locked, align_err, overflow;

    lvds_ddr_aligner_if #(.FRAME_W(FRAME_W)) fif ();

    lvds_ddr_aligner #(
        .LANES(2), .RATIO(2), .FRAME_W(FRAME_W),
        .TRAIN_WORD(8'hA5), .MATCH_COUNT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .din_rise_i(din_rise), .din_fall_i(din_fall),
        .train_en_i(train_en), .frame_if(fif),
        .locked_o(locked), .align_err_o(align_err), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q [$];
    logic [7:0] tw = 8'hA5;

    typedef struct packed {
        logic [1:0] f0, r0, f1, r1;
        logic [7:0] exp;
    } vec_t;
    vec_t       vecs [6];
    logic [3:0] pb [16];
    logic [7:0] g [3];
    logic [7:0] fb [3];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, req);
        end
    endtask

    // consumer side: every transfer must match the next expected frame
    always @(negedge clk) begin
        if (!rst && fif.frame_valid && fif.frame_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_frame: got 0x%0h, want no frame", fif.frame_data);
            end else begin
                check("frame_out", 32'(fif.frame_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "timeout");
    end

    task automatic do_reset(input int n);
        rst = 1'b1; train_en = 1'b0; fif.frame_ready = 1'b0;
        din_rise = '0; din_fall = '0;
        exp_q.delete();
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cyc(input logic [1:0] f, input logic [1:0] r);
        din_fall = f; din_rise = r;
        @(posedge clk);
        #1;
    endtask

    task automatic beat0(input logic [3:0] b);
        cyc({b[2], b[0]}, {b[3], b[1]});
    endtask

    task automatic frame0(input logic [7:0] fr);
        beat0(fr[3:0]);
        beat0(fr[7:4]);
    endtask

    task automatic train_lock(input string tag);
        for (int k = 0; k < 3; k++) frame0(tw);
        beat0(tw[3:0]);
        check({tag, "_locked_early"}, 32'(locked), 32'd0);
        beat0(tw[7:4]);
        check({tag, "_locked"}, 32'(locked), 32'd1);
        check({tag, "_align_err"}, 32'(align_err), 32'd0);
    endtask

    initial begin
        vecs[0] = '{f0: 2'b00, r0: 2'b11, f1: 2'b11, r1: 2'b00, exp: 8'h5A};
        vecs[1] = '{f0: 2'b01, r0: 2'b00, f1: 2'b00, r1: 2'b10, exp: 8'h81};
        vecs[2] = '{f0: 2'b10, r0: 2'b01, f1: 2'b11, r1: 2'b11, exp: 8'hF6};
        vecs[3] = '{f0: 2'b00, r0: 2'b00, f1: 2'b01, r1: 2'b01, exp: 8'h30};
        vecs[4] = '{f0: 2'b11, r0: 2'b10, f1: 2'b10, r1: 2'b00, exp: 8'h4D};
        vecs[5] = '{f0: 2'b01, r0: 2'b01, f1: 2'b10, r1: 2'b10, exp: 8'hC3};
        for (int k = 0; k < 16; k++) pb[k] = (k % 2 == 0) ? 4'h5 : 4'hA;
        g[0] = 8'h12; g[1] = 8'h34; g[2] = 8'h56;
        fb[0] = 8'hC3; fb[1] = 8'h96; fb[2] = 8'h0F;

        // reset state
        do_reset(2);
        check("rst_valid", 32'(fif.frame_valid), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_align_err", 32'(align_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_data", 32'(fif.frame_data), 32'd0);

        // aligned phase-0 training, then table of locked frames
        train_en = 1'b1;
        train_lock("aligned");
        train_en = 1'b0;
        fif.frame_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp);
            cyc(vecs[i].f0, vecs[i].r0);
            cyc(vecs[i].f1, vecs[i].r1);
            check($sformatf("vec%0d_valid", i), 32'(fif.frame_valid), 32'd1);
            check($sformatf("vec%0d_data", i), 32'(fif.frame_data), 32'(vecs[i].exp));
        end

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 3; i++) exp_q.push_back(g[i]);
        beat0(g[0][3:0]);
        fif.frame_ready = 1'b0;
        beat0(g[0][7:4]);
        frame0(g[1]);
        check("full_hold_data", 32'(fif.frame_data), 32'(g[0]));
        beat0(g[2][3:0]);
        check("full_hold_data2", 32'(fif.frame_data), 32'(g[0]));
        fif.frame_ready = 1'b1;
        beat0(g[2][7:4]);
        check("pushpop_overflow", 32'(overflow), 32'd0);
        check("pushpop_head", 32'(fif.frame_data), 32'(g[1]));
        train_en = 1'b1;
        beat0(4'h5);
        beat0(4'hA);
        check("pushpop_drained", 32'(fif.frame_valid), 32'd0);
        check("pushpop_queue", 32'(exp_q.size()), 32'd0);

        // stream delayed by one beat: one slip, then lock
        do_reset(2);
        train_en = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            beat0((k % 2 == 0) ? 4'hA : 4'h5);
            if (k == 9)  check("offset_locked_early", 32'(locked), 32'd0);
            if (k == 10) check("offset_locked", 32'(locked), 32'd1);
        end
        train_en = 1'b0;
        fif.frame_ready = 1'b1;
        exp_q.push_back(8'h3C);
        beat0(4'hC);
        beat0(4'h3);
        check("offset_first_valid", 32'(fif.frame_valid), 32'd1);
        check("offset_first_data", 32'(fif.frame_data), 32'h3C);
        beat0(4'h0);
        check("offset_queue", 32'(exp_q.size()), 32'd0);

        // stream needing phase 1
        do_reset(2);
        train_en = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            cyc({pb[k][3], pb[k][1]}, {pb[k+1][2], pb[k+1][0]});
            if (k == 12) check("phase_locked_early", 32'(locked), 32'd0);
            if (k == 13) check("phase_locked", 32'(locked), 32'd1);
        end
        check("phase_align_err", 32'(align_err), 32'd0);

        // no training pattern: sweep fails after four frames
        do_reset(2);
        train_en = 1'b1;
        for (int k = 0; k < 10; k++) cyc(2'b00, 2'b00);
        check("notrain_err_early", 32'(align_err), 32'd0);
        cyc(2'b00, 2'b00);
        check("notrain_err", 32'(align_err), 32'd1);
        for (int k = 0; k < 6; k++) cyc(2'b00, 2'b00);
        check("notrain_err_sticky", 32'(align_err), 32'd1);
        check("notrain_locked", 32'(locked), 32'd0);

        // backpressure overflow, retrain without slip, reset with buffered frame
        do_reset(2);
        train_en = 1'b1;
        train_lock("bp");
        train_en = 1'b0;
        exp_q.push_back(fb[0]);
        exp_q.push_back(fb[1]);
        frame0(fb[0]);
        check("bp_valid", 32'(fif.frame_valid), 32'd1);
        check("bp_data1", 32'(fif.frame_data), 32'(fb[0]));
        frame0(fb[1]);
        check("bp_overflow_early", 32'(overflow), 32'd0);
        check("bp_data2", 32'(fif.frame_data), 32'(fb[0]));
        frame0(fb[2]);
        check("bp_overflow", 32'(overflow), 32'd1);
        check("bp_data3", 32'(fif.frame_data), 32'(fb[0]));
        train_en = 1'b1;
        fif.frame_ready = 1'b1;
        beat0(tw[3:0]);
        check("retrain_unlock", 32'(locked), 32'd0);
        beat0(tw[7:4]);
        check("bp_drained", 32'(fif.frame_valid), 32'd0);
        check("bp_queue", 32'(exp_q.size()), 32'd0);
        frame0(tw);
        frame0(tw);
        beat0(tw[3:0]);
        check("retrain_locked_early", 32'(locked), 32'd0);
        beat0(tw[7:4]);
        check("retrain_locked", 32'(locked), 32'd1);
        train_en = 1'b0;
        fif.frame_ready = 1'b0;
        exp_q.push_back(8'h77);
        frame0(8'h77);
        check("buf1_valid", 32'(fif.frame_valid), 32'd1);
        check("buf1_data", 32'(fif.frame_data), 32'h77);
        do_reset(1);
        check("midrst_valid", 32'(fif.frame_valid), 32'd0);
        check("midrst_locked", 32'(locked), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_data", 32'(fif.frame_data), 32'd0);
        train_en = 1'b1;
        train_lock("relock");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
